// File: rtl/uart_rx_frame_deserializer.sv
// rtl/uart_rx_frame_deserializer.sv - UART RX frame deserializer with parity/stop check and valid/ready holding register
// Assembles data, parity and stop bits from sampler strobes; frames complete into a single-entry output register.
module uart_rx_frame_deserializer #(
   parameter int  DATA_WIDTH = 8,
   localparam int CW         = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CW-1:0]         cfg_data_bits,
   input  logic                  cfg_parity_en,
   input  logic                  cfg_parity_odd,
   input  logic                  cfg_msb_first,
   input  logic                  frame_start,
   input  logic                  bit_valid,
   input  logic                  sampled_bit,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_parity_err,
   output logic                  out_frame_err,
   output logic                  overrun,
   input  logic                  clear_overrun,
   output logic                  busy
);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   localparam logic [CW-1:0] LP_DW = CW'(DATA_WIDTH);

   state_t                r_state;
   state_t                w_state_next;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         r_n;
   logic                  r_par_en;
   logic                  r_par_odd;
   logic                  r_msb;
   logic                  r_par_acc;
   logic                  r_perr;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;
   logic                  r_out_perr;
   logic                  r_out_ferr;
   logic                  r_overrun;

   logic [CW-1:0]         w_cnt_inc;
   logic [CW-1:0]         w_idx;
   logic [CW-1:0]         w_n_cfg;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic                  w_bit_take;
   logic                  w_stop;
   logic                  w_free;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_inc    = r_cnt + 1'b1;
      // frame_start has priority over any strobe in the same cycle
      w_bit_take   = bit_valid && !frame_start;
      if (frame_start) begin
         w_state_next = S_DATA;
      end else begin
         case (r_state)
            S_DATA:   if (bit_valid && (w_cnt_inc == r_n))
                         w_state_next = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (bit_valid) w_state_next = S_STOP;
            S_STOP:   if (bit_valid) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_n_cfg = ((cfg_data_bits == '0) || (cfg_data_bits > LP_DW)) ? LP_DW : cfg_data_bits;
      w_idx   = r_msb ? (r_n - CW'(1) - r_cnt) : r_cnt;
      w_shift_next = r_shift;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (w_idx == i[CW-1:0]) w_shift_next[i] = sampled_bit;
      end
      w_stop = (r_state == S_STOP) && w_bit_take;
      w_free = !r_out_valid || out_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt       <= '0;
         r_n         <= '0;
         r_par_en    <= 1'b0;
         r_par_odd   <= 1'b0;
         r_msb       <= 1'b0;
         r_par_acc   <= 1'b0;
         r_perr      <= 1'b0;
         r_shift     <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_perr  <= 1'b0;
         r_out_ferr  <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (frame_start) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_par_acc <= 1'b0;
            r_perr    <= 1'b0;
            r_n       <= w_n_cfg;
            r_par_en  <= cfg_parity_en;
            r_par_odd <= cfg_parity_odd;
            r_msb     <= cfg_msb_first;
         end else if (bit_valid) begin
            if (r_state == S_DATA) begin
               r_shift   <= w_shift_next;
               r_cnt     <= w_cnt_inc;
               r_par_acc <= r_par_acc ^ sampled_bit;
            end else if (r_state == S_PARITY) begin
               r_perr <= r_par_acc ^ sampled_bit ^ r_par_odd;
            end
         end

         if (w_stop && w_free) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_shift;
            r_out_perr  <= r_par_en & r_perr;
            r_out_ferr  <= !sampled_bit;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_stop && !w_free) r_overrun <= 1'b1;
         else if (clear_overrun) r_overrun <= 1'b0;
      end
   end

   assign out_data       = r_out_data;
   assign out_valid      = r_out_valid;
   assign out_parity_err = r_out_perr;
   assign out_frame_err  = r_out_ferr;
   assign overrun        = r_overrun;
   assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_deserializer.sv
// tb/tb_uart_rx_frame_deserializer.sv - directed self-checking bench for uart_rx_frame_deserializer
// Inputs change 1ns after posedge; outputs are checked at the same point.
module tb_uart_rx_frame_deserializer;

   localparam int DW = 8;
   localparam int CW = $clog2(DW + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic [CW-1:0] cfg_data_bits;
   logic          cfg_parity_en, cfg_parity_odd, cfg_msb_first;
   logic          frame_start, bit_valid, sampled_bit;
   logic [DW-1:0] out_data;
   logic          out_valid, out_ready, out_parity_err, out_frame_err;
   logic          overrun, clear_overrun, busy;

   int checks = 0;
   int errors = 0;

   uart_rx_frame_deserializer #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
      .cfg_parity_odd(cfg_parity_odd), .cfg_msb_first(cfg_msb_first),
      .frame_start(frame_start), .bit_valid(bit_valid), .sampled_bit(sampled_bit),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_parity_err(out_parity_err), .out_frame_err(out_frame_err),
      .overrun(overrun), .clear_overrun(clear_overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [CW-1:0] n, input logic pen, input logic podd, input logic msb);
      cfg_data_bits  = n;
      cfg_parity_en  = pen;
      cfg_parity_odd = podd;
      cfg_msb_first  = msb;
   endtask

   task automatic start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      bit_valid   = 1'b1;
      sampled_bit = b;
      tick();
      bit_valid   = 1'b0;
      sampled_bit = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] seq, input int nb);
      for (int i = 0; i < nb; i++) send_bit(seq[i]);
   endtask

   // seq bit i is the i-th bit on the line; optional ready/clear on the stop edge
   task automatic frame(input logic [15:0] seq, input int nb, input logic has_par, input logic par,
                        input logic stop, input logic rdy_stop, input logic clr_stop);
      start();
      send_bits(seq, nb);
      if (has_par) send_bit(par);
      out_ready     = rdy_stop;
      clear_overrun = clr_stop;
      send_bit(stop);
      out_ready     = 1'b0;
      clear_overrun = 1'b0;
   endtask

   task automatic accept();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; frame_start = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b0;
      out_ready = 1'b0; clear_overrun = 1'b0;
      cfg(4'd8, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      reset = 1'b0;
      chk("rst_valid", 16'(out_valid), 16'h0);
      chk("rst_data", 16'(out_data), 16'h0);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_overrun", 16'(overrun), 16'h0);

      // 8N1 LSB-first A5, with latency check before the stop strobe
      bit_valid = 1'b1; sampled_bit = 1'b1; tick(); bit_valid = 1'b0;
      chk("idle_bit_ignored", 16'(busy), 16'h0);
      start();
      chk("busy_after_start", 16'(busy), 16'h1);
      send_bits(16'hA5, 8);
      chk("t1_not_yet_valid", 16'(out_valid), 16'h0);
      send_bit(1'b1);
      chk("t1_valid", 16'(out_valid), 16'h1);
      chk("t1_data", 16'(out_data), 16'hA5);
      chk("t1_perr", 16'(out_parity_err), 16'h0);
      chk("t1_ferr", 16'(out_frame_err), 16'h0);
      chk("t1_busy", 16'(busy), 16'h0);
      tick();
      chk("t1_hold", 16'(out_data), 16'hA5);
      accept();
      chk("t1_accepted", 16'(out_valid), 16'h0);

      // 7 bits MSB-first even parity, data 1010101 -> 0x55
      cfg(4'd7, 1'b1, 1'b0, 1'b1);
      frame(16'h0055, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t2a_data", 16'(out_data), 16'h55);
      chk("t2a_perr", 16'(out_parity_err), 16'h0);
      accept();
      frame(16'h0055, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t2b_data", 16'(out_data), 16'h55);
      chk("t2b_perr", 16'(out_parity_err), 16'h1);
      accept();

      // odd parity, MSB-first 8 bits: line 1,1,0,0,0,0,0,0 -> 0xC0, two ones, parity 1 is correct
      cfg(4'd8, 1'b1, 1'b1, 1'b1);
      frame(16'h0003, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("odd_data", 16'(out_data), 16'hC0);
      chk("odd_perr", 16'(out_parity_err), 16'h0);
      accept();

      // 3 data bits LSB-first: upper bits zero
      cfg(4'd3, 1'b0, 1'b0, 1'b0);
      frame(16'h0005, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("n3_data", 16'(out_data), 16'h05);
      accept();

      // cfg_data_bits=0 means full width; cfg change mid-frame must not apply
      cfg(4'd0, 1'b0, 1'b0, 1'b0);
      start();
      cfg(4'd4, 1'b1, 1'b0, 1'b1);
      send_bits(16'h00A5, 8);
      send_bit(1'b1);
      chk("n0_data", 16'(out_data), 16'hA5);
      chk("n0_perr", 16'(out_parity_err), 16'h0);
      accept();

      // 8N1 3C with bad stop bit
      cfg(4'd8, 1'b0, 1'b0, 1'b0);
      frame(16'h003C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_data", 16'(out_data), 16'h3C);
      chk("t3_ferr", 16'(out_frame_err), 16'h1);
      chk("t3_valid", 16'(out_valid), 16'h1);
      accept();

      // overrun with out_ready held low
      frame(16'h0011, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4_no_overrun", 16'(overrun), 16'h0);
      frame(16'h0022, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4_data_held", 16'(out_data), 16'h11);
      chk("t4_overrun", 16'(overrun), 16'h1);
      chk("t4_valid", 16'(out_valid), 16'h1);
      clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
      chk("t4_cleared", 16'(overrun), 16'h0);
      chk("t4_still_11", 16'(out_data), 16'h11);

      // accept and new completion on the same edge
      frame(16'h0022, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t5_data", 16'(out_data), 16'h22);
      chk("t5_valid", 16'(out_valid), 16'h1);
      chk("t5_overrun", 16'(overrun), 16'h0);

      // set and clear of overrun on the same edge: set wins
      frame(16'h0033, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("set_wins", 16'(overrun), 16'h1);
      chk("set_wins_data", 16'(out_data), 16'h22);

      // reset mid-frame with a held frame and sticky overrun
      start();
      send_bits(16'h000F, 4);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("t6_rst_valid", 16'(out_valid), 16'h0);
      chk("t6_rst_data", 16'(out_data), 16'h0);
      chk("t6_rst_overrun", 16'(overrun), 16'h0);
      chk("t6_rst_busy", 16'(busy), 16'h0);
      frame(16'h005A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t6_data", 16'(out_data), 16'h5A);
      chk("t6_ferr", 16'(out_frame_err), 16'h0);
      accept();

      // restart via frame_start mid-frame, with a coincident bit_valid ignored
      cfg(4'd8, 1'b1, 1'b0, 1'b0);
      start();
      send_bits(16'h000F, 4);
      cfg(4'd8, 1'b0, 1'b0, 1'b0);
      bit_valid = 1'b1; sampled_bit = 1'b1;
      start();
      bit_valid = 1'b0; sampled_bit = 1'b0;
      send_bits(16'h005A, 8);
      send_bit(1'b1);
      chk("t6b_valid", 16'(out_valid), 16'h1);
      chk("t6b_data", 16'(out_data), 16'h5A);
      chk("t6b_perr", 16'(out_parity_err), 16'h0);
      chk("t6b_ferr", 16'(out_frame_err), 16'h0);
      accept();
      chk("t6b_accepted", 16'(out_valid), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
